frame_pulse_scheduler: RTL and testbench

Producer-side counterpart of the per-frame edge detection path. It accepts bursty event requests from game logic (bumper hits, score triggers) and replays them as clean, frame-aligned pulses. It emits at most one pulse per FRAME_GAP frames, always starting on startOfFrame. Sits between collision/score logic and any consumer that samples events once per frame (sound trigger, score counter, flasher).

---
 rtl/frame_pulse_scheduler_pkg.sv | 18 +
 rtl/frame_pulse_scheduler_request_rise_capture.sv | 35 +++
 rtl/frame_pulse_scheduler.sv | 147 ++++++++++++++
 tb/tb_frame_pulse_scheduler.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/frame_pulse_scheduler_pkg.sv
// ---------------------------------------------------------------------------
// pinball_pulse_pkg
// Shared types and counter widths for frame_pulse_scheduler.
//   pulse_state_t : scheduler state (IDLE / PULSE)
//   PULSE_CNT_W   : width of the in-pulse cycle counter (PULSE_CYCLES <= 255)
//   GAP_CNT_W     : width of the inter-pulse frame gap counter (FRAME_GAP <= 15)
// ---------------------------------------------------------------------------
package pinball_pulse_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    PULSE = 1'b1
  } pulse_state_t;

  localparam int PULSE_CNT_W = 8;
  localparam int GAP_CNT_W   = 4;

endpackage

// File: rtl/frame_pulse_scheduler_request_rise_capture.sv
// ---------------------------------------------------------------------------
// request_rise_capture
// Registers the previous level of the request line and flags its rising edge,
// so a request held high for many cycles counts as a single event.
// Ports:
//   clk      in  system clock
//   reset    in  synchronous active-high reset (clears request history)
//   request  in  level event request
//   req_rise out request && !previous request (combinational)
// ---------------------------------------------------------------------------
module request_rise_capture (
  input  logic clk,
  input  logic reset,
  input  logic request,
  output logic req_rise
);

  logic request_prev_q;
  logic request_prev_d;

  always_comb begin
    request_prev_d = request;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      request_prev_q <= 1'b0;
    end else begin
      request_prev_q <= request_prev_d;
    end
  end

  assign req_rise = request & ~request_prev_q;

endmodule

// File: rtl/frame_pulse_scheduler.sv
// ---------------------------------------------------------------------------
// frame_pulse_scheduler
// Queues bursty event requests and replays them as clean pulses that start
// one cycle after a startOfFrame strobe, at most one pulse per FRAME_GAP frames.
//
// Parameters:
//   COUNT_WIDTH  width of the pending-request counter (max 2^COUNT_WIDTH-1)
//   PULSE_CYCLES pulse high time in clk cycles (1..255), shorter than a frame
//   FRAME_GAP    minimum frames between pulse starts (1..15)
//
// Ports:
//   clk           in   system clock
//   reset         in   synchronous active-high reset
//   startOfFrame  in   one-cycle strobe at frame start
//   request       in   level request; only its rising edge is counted
//   flush         in   (only with FRAME_PULSE_FLUSH_EN) clears the queue
//   pulseOut      out  registered frame-aligned pulse, PULSE_CYCLES wide
//   busy          out  registered, high while the state is PULSE (state view)
//   pendingCount  out  registered count of queued, not yet emitted requests
//   overflow      out  sticky flag: a request was lost at saturation
//
// Optional feature macro: FRAME_PULSE_FLUSH_EN adds the flush input. When the
// macro is undefined the port and its logic are absent.
// ---------------------------------------------------------------------------
module frame_pulse_scheduler
  import pinball_pulse_pkg::*;
#(
  parameter int COUNT_WIDTH  = 4,
  parameter int PULSE_CYCLES = 1,
  parameter int FRAME_GAP    = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   startOfFrame,
  input  logic                   request,
`ifdef FRAME_PULSE_FLUSH_EN
  input  logic                   flush,
`endif
  output logic                   pulseOut,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] pendingCount,
  output logic                   overflow
);

  localparam logic [PULSE_CNT_W-1:0] PULSE_LOAD = PULSE_CNT_W'(PULSE_CYCLES - 1);
  localparam logic [GAP_CNT_W-1:0]   GAP_LOAD   = GAP_CNT_W'(FRAME_GAP - 1);
  localparam logic [COUNT_WIDTH-1:0] CNT_MAX    = {COUNT_WIDTH{1'b1}};

  pulse_state_t            state_q, state_d;
  logic [PULSE_CNT_W-1:0]  pulse_cnt_q, pulse_cnt_d;
  logic [GAP_CNT_W-1:0]    gap_cnt_q, gap_cnt_d;
  logic [COUNT_WIDTH-1:0]  pending_q, pending_d;
  logic                    overflow_q, overflow_d;
  logic                    pulse_out_q, pulse_out_d;
  logic                    busy_q, busy_d;

  logic                    req_rise;
  logic                    start;
  logic                    flush_i;

`ifdef FRAME_PULSE_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  request_rise_capture u_rise (
    .clk      (clk),
    .reset    (reset),
    .request  (request),
    .req_rise (req_rise)
  );

  always_comb begin
    state_d     = state_q;
    pulse_cnt_d = pulse_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    pending_d   = pending_q;
    overflow_d  = overflow_q;

    // A pulse only launches on a strobe while idle, with work queued and the
    // frame gap elapsed; a flush in the same cycle suppresses it.
    start = startOfFrame && (pending_q != '0) && (gap_cnt_q == '0) &&
            (state_q == IDLE) && !flush_i;

    if (start) begin
      state_d     = PULSE;
      pulse_cnt_d = PULSE_LOAD;
      gap_cnt_d   = GAP_LOAD;
    end else begin
      if (state_q == PULSE) begin
        if (pulse_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          pulse_cnt_d = pulse_cnt_q - PULSE_CNT_W'(1);
        end
      end
      // Gap counts strobes in both states, including strobes during a pulse.
      if (startOfFrame && (gap_cnt_q != '0)) begin
        gap_cnt_d = gap_cnt_q - GAP_CNT_W'(1);
      end
    end

    // Simultaneous increment and decrement cancel, even when saturated.
    if (flush_i) begin
      pending_d  = '0;
      overflow_d = 1'b0;
    end else if (req_rise && !start) begin
      if (pending_q == CNT_MAX) begin
        overflow_d = 1'b1;
      end else begin
        pending_d = pending_q + COUNT_WIDTH'(1);
      end
    end else if (!req_rise && start) begin
      pending_d = pending_q - COUNT_WIDTH'(1);
    end

    pulse_out_d = (state_d == PULSE);
    busy_d      = (state_d == PULSE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      pulse_cnt_q <= '0;
      gap_cnt_q   <= '0;
      pending_q   <= '0;
      overflow_q  <= 1'b0;
      pulse_out_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      pulse_cnt_q <= pulse_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      pending_q   <= pending_d;
      overflow_q  <= overflow_d;
      pulse_out_q <= pulse_out_d;
      busy_q      <= busy_d;
    end
  end

  assign pulseOut     = pulse_out_q;
  assign busy         = busy_q;
  assign pendingCount = pending_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_frame_pulse_scheduler.sv
// ---------------------------------------------------------------------------
// tb_frame_pulse_scheduler
// Two scheduler instances share one stimulus stream:
//   u0 : COUNT_WIDTH=4, PULSE_CYCLES=1, FRAME_GAP=1
//   u1 : COUNT_WIDTH=2, PULSE_CYCLES=5, FRAME_GAP=3
// Each is compared every cycle against a timestamp-based reference model;
// directed table rows and corner-case sequences add explicit expectations.
// Build with FRAME_PULSE_FLUSH_EN defined to exercise the flush input.
// ---------------------------------------------------------------------------
module tb_frame_pulse_scheduler;

`ifdef FRAME_PULSE_FLUSH_EN
  localparam bit FLUSH_EN = 1'b1;
`else
  localparam bit FLUSH_EN = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, sof, req, flush;
  logic p0, b0, o0;
  logic [3:0] pc0;
  logic p1, b1, o1;
  logic [1:0] pc1;

  frame_pulse_scheduler #(.COUNT_WIDTH(4), .PULSE_CYCLES(1), .FRAME_GAP(1)) u0 (
    .clk          (clk),
    .reset        (rst),
    .startOfFrame (sof),
    .request      (req),
`ifdef FRAME_PULSE_FLUSH_EN
    .flush        (flush),
`endif
    .pulseOut     (p0),
    .busy         (b0),
    .pendingCount (pc0),
    .overflow     (o0)
  );

  frame_pulse_scheduler #(.COUNT_WIDTH(2), .PULSE_CYCLES(5), .FRAME_GAP(3)) u1 (
    .clk          (clk),
    .reset        (rst),
    .startOfFrame (sof),
    .request      (req),
`ifdef FRAME_PULSE_FLUSH_EN
    .flush        (flush),
`endif
    .pulseOut     (p1),
    .busy         (b1),
    .pendingCount (pc1),
    .overflow     (o1)
  );

  // ---------------- reference model ----------------
  // Pulses are tracked by the edge index at which they were launched; the
  // frame gap by the number of non-launching strobes seen since the launch.
  typedef struct {
    int cyc;
    bit has_s;
    int last_s;
    int sss;
    int pending;
    bit ovf;
    bit prev_req;
  } model_t;

  model_t m0, m1;

  function automatic model_t model_step(model_t m, bit r, bit s, bit q, bit f,
                                        int p, int g, int maxc);
    model_t n;
    bit rise, busy_before, launch;
    n = m;
    n.cyc = m.cyc + 1;
    if (r) begin
      n.has_s = 1'b0; n.sss = g; n.pending = 0; n.ovf = 1'b0; n.prev_req = 1'b0;
      return n;
    end
    rise = q && !m.prev_req;
    n.prev_req = q;
    busy_before = m.has_s && (m.cyc >= m.last_s) && (m.cyc <= m.last_s + p - 1);
    launch = s && (m.pending > 0) && (m.sss + 1 >= g) && !busy_before && !f;
    if (launch) begin
      n.has_s = 1'b1; n.last_s = n.cyc; n.sss = 0;
    end else if (s && m.sss < g) begin
      n.sss = m.sss + 1;
    end
    if (f) begin
      n.pending = 0; n.ovf = 1'b0;
    end else begin
      n.pending = m.pending + (rise ? 1 : 0) - (launch ? 1 : 0);
      if (n.pending > maxc) begin
        n.pending = maxc; n.ovf = 1'b1;
      end
    end
    return n;
  endfunction

  function automatic bit model_pulse(model_t m, int p);
    return m.has_s && (m.cyc >= m.last_s) && (m.cyc <= m.last_s + p - 1);
  endfunction

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_models();
    check("u0_pulse", 32'(p0),  32'(model_pulse(m0, 1)));
    check("u0_busy",  32'(b0),  32'(model_pulse(m0, 1)));
    check("u0_pend",  32'(pc0), 32'(m0.pending));
    check("u0_ovf",   32'(o0),  32'(m0.ovf));
    check("u1_pulse", 32'(p1),  32'(model_pulse(m1, 5)));
    check("u1_busy",  32'(b1),  32'(model_pulse(m1, 5)));
    check("u1_pend",  32'(pc1), 32'(m1.pending));
    check("u1_ovf",   32'(o1),  32'(m1.ovf));
  endtask

  // ---------------- driver ----------------
  task automatic step(input bit r, input bit s, input bit q, input bit f);
    rst = r; sof = s; req = q; flush = f;
    @(posedge clk);
    m0 = model_step(m0, r, s, q, FLUSH_EN && f, 1, 1, 15);
    m1 = model_step(m1, r, s, q, FLUSH_EN && f, 5, 3, 3);
    #1;
    check_models();
  endtask

  // ---------------- directed table (u0 expectations) ----------------
  typedef struct {
    bit rst, sof, req;
    bit exp_pulse, exp_busy;
    int exp_pend;
    bit exp_ovf;
  } vec_t;

  vec_t vecs[15];

  initial begin
    logic [4:0] mask;
    int rises, prev_p, hi_cnt, countdown;

    rst = 1'b1; sof = 1'b0; req = 1'b0; flush = 1'b0;
    m0 = '{cyc: 0, has_s: 1'b0, last_s: 0, sss: 1, pending: 0, ovf: 1'b0, prev_req: 1'b0};
    m1 = '{cyc: 0, has_s: 1'b0, last_s: 0, sss: 3, pending: 0, ovf: 1'b0, prev_req: 1'b0};

    //          rst sof req  pulse busy pend ovf
    vecs[0]  = '{1, 0, 0,   0, 0, 0, 0};
    vecs[1]  = '{0, 0, 1,   0, 0, 1, 0};
    vecs[2]  = '{0, 0, 0,   0, 0, 1, 0};
    vecs[3]  = '{0, 0, 1,   0, 0, 2, 0};
    vecs[4]  = '{0, 0, 0,   0, 0, 2, 0};
    vecs[5]  = '{0, 0, 1,   0, 0, 3, 0};
    vecs[6]  = '{0, 0, 0,   0, 0, 3, 0};
    vecs[7]  = '{0, 1, 0,   1, 1, 2, 0};
    vecs[8]  = '{0, 0, 0,   0, 0, 2, 0};
    vecs[9]  = '{0, 0, 0,   0, 0, 2, 0};
    vecs[10] = '{0, 1, 0,   1, 1, 1, 0};
    vecs[11] = '{0, 0, 0,   0, 0, 1, 0};
    vecs[12] = '{0, 1, 0,   1, 1, 0, 0};
    vecs[13] = '{0, 0, 0,   0, 0, 0, 0};
    vecs[14] = '{0, 1, 0,   0, 0, 0, 0};

    for (int i = 0; i < 15; i++) begin
      step(vecs[i].rst, vecs[i].sof, vecs[i].req, 1'b0);
      check("vec_pulse", 32'(p0),  32'(vecs[i].exp_pulse));
      check("vec_busy",  32'(b0),  32'(vecs[i].exp_busy));
      check("vec_pend",  32'(pc0), 32'(vecs[i].exp_pend));
      check("vec_ovf",   32'(o0),  32'(vecs[i].exp_ovf));
    end

    // Held request across two frames: one queued event, one pulse.
    step(1, 0, 0, 0);
    rises = 0; prev_p = 0;
    for (int i = 0; i < 500; i++) begin
      step(0, (i == 100) || (i == 350), 1, 0);
      if (i == 99) check("held_pend", 32'(pc0), 32'd1);
      if (p0 && !prev_p) rises++;
      prev_p = p0;
    end
    check("held_pulses", 32'(rises), 32'd1);
    check("held_pend_end", 32'(pc0), 32'd0);

    // Frame gap of 3 on u1: pulses at frames 0 and 3 only.
    step(1, 0, 0, 0);
    step(0, 0, 1, 0); step(0, 0, 0, 0);
    step(0, 0, 1, 0); step(0, 0, 0, 0);
    check("gap_pend", 32'(pc1), 32'd2);
    mask = '0;
    for (int f = 0; f < 5; f++) begin
      step(0, 1, 0, 0);
      mask[f] = p1;
      for (int k = 0; k < 19; k++) step(0, 0, 0, 0);
    end
    check("gap_frames", 32'(mask), 32'b01001);
    check("gap_pend_end", 32'(pc1), 32'd0);

    // Saturation on u1 (max 3), then rise coincident with a launch.
    step(1, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);
    end
    check("sat_pend", 32'(pc1), 32'd3);
    check("sat_ovf",  32'(o1),  32'd1);
    step(0, 1, 1, 0);
    check("sat_cancel_pend", 32'(pc1), 32'd3);
    check("sat_cancel_ovf",  32'(o1),  32'd1);
    check("sat_cancel_pulse", 32'(p1), 32'd1);

    // Reset during the third pulse cycle truncates the pulse.
    step(0, 0, 1, 0);
    step(0, 0, 1, 0);
    check("mid_pulse_high", 32'(p1), 32'd1);
    step(1, 0, 0, 0);
    check("rst_pulse", 32'(p1),  32'd0);
    check("rst_busy",  32'(b1),  32'd0);
    check("rst_pend",  32'(pc1), 32'd0);
    check("rst_ovf",   32'(o1),  32'd0);

`ifdef FRAME_PULSE_FLUSH_EN
    // Flush during an active pulse: pulse keeps its full width, queue empties.
    step(0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 1, 0);
      step(0, 0, 0, 0);
    end
    step(0, 1, 0, 0);
    check("flush_pend_before", 32'(pc1), 32'd2);
    hi_cnt = p1 ? 1 : 0;
    step(0, 0, 0, 1);
    check("flush_pend", 32'(pc1), 32'd0);
    if (p1) hi_cnt++;
    for (int i = 0; i < 60; i++) begin
      step(0, (i % 12) == 11, 0, 0);
      if (p1) hi_cnt++;
    end
    check("flush_width", 32'(hi_cnt), 32'd5);
    check("flush_pend_end", 32'(pc1), 32'd0);
`endif

    // Randomized traffic against the model.
    step(1, 0, 0, 0);
    countdown = $urandom_range(8, 25);
    for (int i = 0; i < 3000; i++) begin
      bit s_r, q_r, r_r, f_r;
      countdown--;
      s_r = (countdown == 0);
      if (s_r) countdown = $urandom_range(8, 25);
      q_r = ($urandom_range(0, 3) == 0) ? ~req : req;
      r_r = ($urandom_range(0, 499) == 0);
      f_r = ($urandom_range(0, 199) == 0);
      step(r_r, s_r, q_r, f_r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
